// File: rtl/button_debounce_if.sv
// Button debouncer signal bundle.
// Raw synchronized level in, clean level and event pulses out.
interface button_debounce_if;
    logic btn_in;
    logic btn_level;
    logic btn_press;
    logic btn_release;
    logic btn_repeat;

    // Producer of the raw level, consumer of the debounced events.
    modport master (
        output btn_in,
        input  btn_level,
        input  btn_press,
        input  btn_release,
        input  btn_repeat
    );

    // The debouncer itself.
    modport slave (
        input  btn_in,
        output btn_level,
        output btn_press,
        output btn_release,
        output btn_repeat
    );
endinterface

// File: rtl/button_debounce.sv
// Per-button debouncer with press/release/auto-repeat pulses.
// Input must already be synchronized to Clk.
module button_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 500_000,
    parameter int unsigned HOLD_CYCLES     = 25_000_000,
    parameter int unsigned REPEAT_CYCLES   = 5_000_000,
    parameter bit          ACTIVE_LOW      = 1'b1
) (
    input  logic             Clk,
    input  logic             Reset_n,
    button_debounce_if.slave btn
);

    localparam int unsigned MAX_AB =
        (DEBOUNCE_CYCLES > HOLD_CYCLES) ? DEBOUNCE_CYCLES : HOLD_CYCLES;
    localparam int unsigned MAX_C =
        (MAX_AB > REPEAT_CYCLES) ? MAX_AB : REPEAT_CYCLES;
    localparam int unsigned CW = $clog2(MAX_C + 1);

    localparam bit RPT_EN = (REPEAT_CYCLES != 0);

    localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] HD_LAST = CW'(HOLD_CYCLES - 1);
    // With repeat disabled the REPEAT state is unreachable; keep the
    // terminal count well defined instead of underflowing.
    localparam logic [CW-1:0] RP_LAST =
        CW'(RPT_EN ? REPEAT_CYCLES - 1 : 0);
    localparam logic [CW-1:0] ONE = CW'(1);

    typedef enum logic [2:0] {
        IDLE         = 3'd0,
        PRESS_WAIT   = 3'd1,
        DOWN         = 3'd2,
        REPEAT       = 3'd3,
        RELEASE_WAIT = 3'd4
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          level;
    logic          press;
    logic          rls;
    logic          rpt;
    logic          p;

    // Normalise polarity so that p = 1 always means pressed.
    assign p = btn.btn_in ^ ACTIVE_LOW;

    // Debounce FSM with stable-sample counter and registered outputs.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state <= IDLE;
            cnt   <= '0;
            level <= 1'b0;
            press <= 1'b0;
            rls   <= 1'b0;
            rpt   <= 1'b0;
        end else begin
            press <= 1'b0;
            rls   <= 1'b0;
            rpt   <= 1'b0;
            case (state)
                IDLE: begin
                    level <= 1'b0;
                    if (p) begin
                        state <= PRESS_WAIT;
                        cnt   <= ONE;
                    end else begin
                        cnt   <= '0;
                    end
                end

                PRESS_WAIT: begin
                    if (!p) begin
                        state <= IDLE;
                        cnt   <= '0;
                        level <= 1'b0;
                    end else if (cnt == DB_LAST) begin
                        state <= DOWN;
                        cnt   <= '0;
                        level <= 1'b1;
                        press <= 1'b1;
                    end else begin
                        cnt   <= cnt + ONE;
                    end
                end

                DOWN: begin
                    level <= 1'b1;
                    if (!p) begin
                        state <= RELEASE_WAIT;
                        cnt   <= ONE;
                    end else if (RPT_EN && cnt == HD_LAST) begin
                        state <= REPEAT;
                        cnt   <= '0;
                        rpt   <= 1'b1;
                    end else if (cnt != HD_LAST) begin
                        cnt   <= cnt + ONE;
                    end
                end

                REPEAT: begin
                    level <= 1'b1;
                    if (!p) begin
                        state <= RELEASE_WAIT;
                        cnt   <= ONE;
                    end else if (cnt == RP_LAST) begin
                        cnt   <= '0;
                        rpt   <= 1'b1;
                    end else begin
                        cnt   <= cnt + ONE;
                    end
                end

                RELEASE_WAIT: begin
                    if (p) begin
                        state <= DOWN;
                        cnt   <= '0;
                        level <= 1'b1;
                    end else if (cnt == DB_LAST) begin
                        state <= IDLE;
                        cnt   <= '0;
                        level <= 1'b0;
                        rls   <= 1'b1;
                    end else begin
                        cnt   <= cnt + ONE;
                        level <= 1'b1;
                    end
                end

                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                    level <= 1'b0;
                end
            endcase
        end
    end

    assign btn.btn_level   = level;
    assign btn.btn_press   = press;
    assign btn.btn_release = rls;
    assign btn.btn_repeat  = rpt;

    // At most one event pulse per cycle.
    always @(posedge Clk) begin
        if (Reset_n) begin
            assert ($onehot0({press, rls, rpt}))
                else $error("multiple event pulses");
        end
    end

    // Press/repeat only while pressed, release only once let go.
    always @(posedge Clk) begin
        if (Reset_n) begin
            assert (!(press || rpt) || level)
                else $error("press/repeat without level");
            assert (!rls || !level)
                else $error("release with level high");
        end
    end

endmodule

// File: tb/tb_button_debounce.sv
// Self-checking bench for button_debounce.
// Three instances: active-high, active-low, repeat disabled.
module tb_button_debounce;

    logic Clk = 1'b0;
    logic Reset_n;

    always #5 Clk = ~Clk;

    button_debounce_if bus0 ();
    button_debounce_if bus1 ();
    button_debounce_if bus2 ();

    button_debounce #(
        .DEBOUNCE_CYCLES(4), .HOLD_CYCLES(10),
        .REPEAT_CYCLES(3), .ACTIVE_LOW(1'b0)
    ) u0 (.Clk(Clk), .Reset_n(Reset_n), .btn(bus0.slave));

    button_debounce #(
        .DEBOUNCE_CYCLES(4), .HOLD_CYCLES(10),
        .REPEAT_CYCLES(3), .ACTIVE_LOW(1'b1)
    ) u1 (.Clk(Clk), .Reset_n(Reset_n), .btn(bus1.slave));

    button_debounce #(
        .DEBOUNCE_CYCLES(4), .HOLD_CYCLES(10),
        .REPEAT_CYCLES(0), .ACTIVE_LOW(1'b0)
    ) u2 (.Clk(Clk), .Reset_n(Reset_n), .btn(bus2.slave));

    // Output vectors: {level, press, release, repeat}
    logic [3:0] o0, o1, o2;
    assign o0 = {bus0.btn_level, bus0.btn_press,
                 bus0.btn_release, bus0.btn_repeat};
    assign o1 = {bus1.btn_level, bus1.btn_press,
                 bus1.btn_release, bus1.btn_repeat};
    assign o2 = {bus2.btn_level, bus2.btn_press,
                 bus2.btn_release, bus2.btn_repeat};

    localparam logic [3:0] Z  = 4'b0000;
    localparam logic [3:0] L  = 4'b1000;
    localparam logic [3:0] PR = 4'b1100;
    localparam logic [3:0] RL = 4'b0010;
    localparam logic [3:0] RP = 4'b1001;

    typedef struct {
        string      tag;
        logic [3:0] e;
    } exp_t;

    exp_t sb[$];

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [3:0] got,
                       input logic [3:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%b exp=%b", tag, got, exp);
        end
    endtask

    task automatic drive(input logic p);
        bus0.btn_in = p;
        bus1.btn_in = ~p;
        bus2.btn_in = p;
    endtask

    task automatic push(input string tag, input logic [3:0] e);
        exp_t x;
        x.tag = tag;
        x.e   = e;
        sb.push_back(x);
    endtask

    // Pop one expectation and compare every instance against it.
    task automatic compare();
        exp_t x;
        x = sb.pop_front();
        chk({x.tag, ".u0"}, o0, x.e);
        chk({x.tag, ".u1"}, o1, x.e);
        chk({x.tag, ".u2"}, o2, {x.e[3:1], 1'b0});
    endtask

    task automatic step(input string tag, input logic p,
                        input logic [3:0] e);
        drive(p);
        push(tag, e);
        @(posedge Clk);
        #1;
        compare();
    endtask

    initial begin
        Reset_n = 1'b1;
        drive(1'b0);
        #2 Reset_n = 1'b0;

        // 1: reset held while input toggles, then quiet idle
        for (int i = 0; i < 8; i++) step("t1.rst", 1'(i & 1), Z);
        Reset_n = 1'b1;
        for (int i = 0; i < 20; i++) step("t1.idle", 1'b0, Z);

        // 2: bouncy press never reaches four stable samples
        begin
            logic [6:0] pat;
            pat = 7'b0111011;
            for (int i = 6; i >= 0; i--) step("t2.bounce", pat[i], Z);
        end
        step("t2.idle", 1'b0, Z);
        step("t2.idle", 1'b0, Z);

        // 3: clean press accepted on the fourth edge
        step("t3.pw", 1'b1, Z);
        step("t3.pw", 1'b1, Z);
        step("t3.pw", 1'b1, Z);
        step("t3.press", 1'b1, PR);

        // 4: hold to edge 30, repeats at 14,17,...,29
        for (int k = 5; k <= 30; k++) begin
            if (k >= 14 && (k - 14) % 3 == 0)
                step("t4.rep", 1'b1, RP);
            else
                step("t4.hold", 1'b1, L);
        end
        step("t4.rw", 1'b0, L);
        step("t4.rw", 1'b0, L);
        step("t4.rw", 1'b0, L);
        step("t4.rel", 1'b0, RL);
        for (int i = 0; i < 3; i++) step("t4.idle", 1'b0, Z);

        // 5: glitches restart the hold timer and the release count
        step("t5.pw", 1'b1, Z);
        step("t5.pw", 1'b1, Z);
        step("t5.pw", 1'b1, Z);
        step("t5.press", 1'b1, PR);
        for (int k = 5; k <= 9; k++) step("t5.hold", 1'b1, L);
        step("t5.glitch0", 1'b0, L);
        step("t5.glitch1", 1'b1, L);
        for (int k = 12; k <= 20; k++) step("t5.restart", 1'b1, L);
        step("t5.rep", 1'b1, RP);
        step("t5.rw", 1'b0, L);
        step("t5.rw", 1'b0, L);
        step("t5.rglitch", 1'b1, L);
        step("t5.rw", 1'b0, L);
        step("t5.rw", 1'b0, L);
        step("t5.rw", 1'b0, L);
        step("t5.rel", 1'b0, RL);
        for (int i = 0; i < 3; i++) step("t5.idle", 1'b0, Z);

        // 6: asynchronous reset in REPEAT, then re-debounce
        step("t6.pw", 1'b1, Z);
        step("t6.pw", 1'b1, Z);
        step("t6.pw", 1'b1, Z);
        step("t6.press", 1'b1, PR);
        for (int k = 5; k <= 13; k++) step("t6.hold", 1'b1, L);
        step("t6.rep", 1'b1, RP);
        step("t6.inrep", 1'b1, L);
        #2 Reset_n = 1'b0;
        #1;
        push("t6.async", Z);
        compare();
        for (int i = 0; i < 3; i++) step("t6.inrst", 1'b1, Z);
        Reset_n = 1'b1;
        step("t6.pw", 1'b1, Z);
        step("t6.pw", 1'b1, Z);
        step("t6.pw", 1'b1, Z);
        step("t6.press", 1'b1, PR);
        step("t6.rw", 1'b0, L);
        step("t6.rw", 1'b0, L);
        step("t6.rw", 1'b0, L);
        step("t6.rel", 1'b0, RL);
        step("t6.idle", 1'b0, Z);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Hard stop in case the stimulus ever stalls.
    initial begin
        #100000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
